// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches instructions over a ready handshake,
// presents each instruction for one execute cycle, resolves beq/brnv, keeps
// the architectural V flag and a retired-instruction counter.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        branch,
    input  logic        brnv,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    input  logic        v_we,
    output logic        v_flag,
    output logic [31:0] retired,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        FAULT
    } state_t;

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};
    localparam int unsigned CW      = $clog2(IMEM_TIMEOUT + 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] wait_cnt;
    logic          timeout;
    logic          taken;
    logic          advance;
    logic          accept;
    logic [31:0]   br_off;
    logic [31:0]   pc_next;

    // Branch resolution uses the V flag held before any same-cycle update.
    always_comb begin
        pc_plus4 = pc + 32'd4;
        br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
        taken    = (branch & alu_zero) | (brnv & ~v_flag);
        pc_next  = taken ? (pc_plus4 + br_off) : pc_plus4;
        timeout  = (wait_cnt == CW'(IMEM_TIMEOUT - 1));
        accept   = (state == FETCH) & imem_ready;
        advance  = (state == EXEC) & ~stall;
    end

    assign imem_addr = pc;

    // State register; reset clears state at once so imem_req drops immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake/valid outputs.
    always_comb begin
        state_nx    = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            IDLE: begin
                state_nx = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_nx = EXEC;
                end else if (timeout) begin
                    state_nx = FAULT;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    state_nx = FETCH;
                end
            end
            FAULT: begin
                state_nx = FAULT;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Fetch wait counter: zero outside FETCH, counts cycles without ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state != FETCH || imem_ready) begin
            wait_cnt <= '0;
        end else if (!timeout) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // Architectural state: instruction latch, PC, V flag, retire count, fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= '0;
            pc          <= PC_INIT;
            v_flag      <= 1'b0;
            retired     <= '0;
            fetch_fault <= 1'b0;
        end else begin
            if (accept) begin
                instr <= imem_rdata;
            end
            if (advance) begin
                pc      <= pc_next;
                retired <= retired + 32'd1;
                if (v_we) begin
                    v_flag <= alu_ovf;
                end
            end
            if (state == FETCH && !imem_ready && timeout) begin
                fetch_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed test-plan cases followed by randomized
// instruction streams, checked against a behavioural PC/V/retire model.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        branch;
    logic        brnv;
    logic        alu_zero;
    logic        alu_ovf;
    logic        v_we;
    logic        v_flag;
    logic [31:0] retired;
    logic        fetch_fault;

    int unsigned tests;
    int unsigned fails;

    // Reference model state
    logic [31:0] mpc;
    logic        mv;
    logic [31:0] mret;

    fetch_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .IMEM_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .stall      (stall),
        .branch     (branch),
        .brnv       (brnv),
        .alu_zero   (alu_zero),
        .alu_ovf    (alu_ovf),
        .v_we       (v_we),
        .v_flag     (v_flag),
        .retired    (retired),
        .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_ctl();
        stall    = 1'b0;
        branch   = 1'b0;
        brnv     = 1'b0;
        alu_zero = 1'b0;
        alu_ovf  = 1'b0;
        v_we     = 1'b0;
    endtask

    // One full fetch/execute of `word`: ready after `lat` idle FETCH cycles,
    // `stalls` held EXEC cycles with random noise, then release with the
    // given control inputs. Called at a negedge; returns at a negedge.
    task automatic run_instr(input logic [31:0] word, input int unsigned lat,
                             input logic br, input logic bn, input logic az,
                             input logic ao, input logic vwe, input int unsigned stalls);
        int unsigned n;
        logic        tk;
        int signed   off;
        logic [15:0] imm;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            chk("req_wait", 32'(imem_req), 32'd1);
            return;
        end
        chk("imem_addr", imem_addr, mpc);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        repeat (lat) begin
            @(negedge clk);
            chk("req_held", 32'(imem_req), 32'd1);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        chk("instr_valid", 32'(instr_valid), 32'd1);
        chk("instr", instr, word);
        chk("pc", pc, mpc);
        chk("pc_plus4", pc_plus4, mpc + 32'd4);
        chk("req_exec", 32'(imem_req), 32'd0);
        chk("no_fault", 32'(fetch_fault), 32'd0);
        repeat (stalls) begin
            stall      = 1'b1;
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            branch     = 1'($urandom);
            brnv       = 1'($urandom);
            alu_zero   = 1'($urandom);
            alu_ovf    = 1'($urandom);
            v_we       = 1'($urandom);
            @(negedge clk);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_pc", pc, mpc);
            chk("stall_ret", retired, mret);
            chk("stall_v", 32'(v_flag), 32'(mv));
            chk("stall_instr", instr, word);
        end
        stall      = 1'b0;
        branch     = br;
        brnv       = bn;
        alu_zero   = az;
        alu_ovf    = ao;
        v_we       = vwe;
        imem_ready = 1'($urandom);
        imem_rdata = $urandom;
        imm = word[15:0];
        off = int'($signed(imm));
        tk  = (br && az) || (bn && !mv);
        @(negedge clk);
        if (tk) mpc = mpc + 32'd4 + 32'(off * 4);
        else    mpc = mpc + 32'd4;
        if (vwe) mv = ao;
        mret = mret + 32'd1;
        chk("next_pc", pc, mpc);
        chk("v_flag", 32'(v_flag), 32'(mv));
        chk("retired", retired, mret);
        chk("valid_drop", 32'(instr_valid), 32'd0);
        clear_ctl();
        imem_ready = 1'b0;
    endtask

    initial begin
        int unsigned n;
        tests      = 0;
        fails      = 0;
        mpc        = 32'h0;
        mv         = 1'b0;
        mret       = 32'h0;
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        clear_ctl();

        // Reset values appear before any clock edge.
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_v", 32'(v_flag), 32'd0);
        chk("rst_ret", retired, 32'h0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("idle_req", 32'(imem_req), 32'd0);

        // First instruction: ready on second FETCH cycle.
        run_instr(32'h1234_0000, 1, 0, 0, 0, 0, 0, 0);
        chk("first_next_addr", pc, 32'h4);
        chk("first_retired", retired, 32'd1);
        // 0x04 -> 0x10
        run_instr(32'h1000_0002, 0, 1, 0, 1, 0, 0, 0);
        chk("to_0x10", pc, 32'h10);
        // beq taken backwards at 0x10
        run_instr(32'h1000_FFFC, 2, 1, 0, 1, 0, 0, 0);
        chk("beq_taken", pc, 32'h04);
        run_instr(32'h1000_0002, 0, 1, 0, 1, 0, 0, 0);
        // beq not taken at 0x10
        run_instr(32'h1000_FFFC, 0, 1, 0, 0, 0, 0, 0);
        chk("beq_not_taken", pc, 32'h14);
        // 0x14 -> 0x20, set V=1
        run_instr(32'h1000_0002, 0, 1, 0, 1, 1, 1, 0);
        chk("v_set", 32'(v_flag), 32'd1);
        // brnv with V=1 not taken; same-cycle clear of V must not matter
        run_instr(32'h2000_0003, 0, 0, 1, 0, 0, 1, 0);
        chk("brnv_not_taken", pc, 32'h24);
        chk("v_cleared", 32'(v_flag), 32'd0);
        run_instr(32'h1000_FFFE, 0, 1, 0, 1, 0, 0, 0);
        // brnv with V=0 taken; same-cycle set of V must not matter
        run_instr(32'h2000_0003, 0, 0, 1, 0, 1, 1, 0);
        chk("brnv_taken", pc, 32'h30);
        chk("v_set2", 32'(v_flag), 32'd1);
        // Three stall cycles then advance
        run_instr(32'h0000_0000, 0, 0, 0, 0, 0, 0, 3);
        chk("stall_advance", pc, 32'h34);
        // Jump to top of address space, then wrap; longest accepted latency
        run_instr(32'h1000_FFF1, 15, 1, 0, 1, 0, 0, 0);
        chk("to_top", pc, 32'hFFFF_FFFC);
        run_instr(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0);
        chk("pc_wrap", pc, 32'h0);

        // Randomized instruction stream
        for (int i = 0; i < 150; i++) begin
            run_instr($urandom, $urandom_range(0, 15),
                      1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        // Reset asserted mid-FETCH
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_fetch_req", 32'(imem_req), 32'd1);
        imem_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req_drop", 32'(imem_req), 32'd0);
        chk("async_pc", pc, 32'h0);
        chk("async_ret", retired, 32'h0);
        chk("async_instr", instr, 32'h0);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("late_ready_ignored", instr, 32'h0);
        chk("refetch_req", 32'(imem_req), 32'd1);
        chk("refetch_addr", imem_addr, 32'h0);
        chk("refetch_valid", 32'(instr_valid), 32'd0);
        mpc  = 32'h0;
        mv   = 1'b0;
        mret = 32'h0;

        // Timeout: no ready for 16 FETCH cycles
        imem_ready = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre_timeout_fault", 32'(fetch_fault), 32'd0);
        chk("pre_timeout_req", 32'(imem_req), 32'd1);
        @(negedge clk);
        chk("timeout_fault", 32'(fetch_fault), 32'd1);
        chk("timeout_req", 32'(imem_req), 32'd0);
        chk("timeout_valid", 32'(instr_valid), 32'd0);
        imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("fault_sticky", 32'(fetch_fault), 32'd1);
        chk("fault_no_req", 32'(imem_req), 32'd0);
        imem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("fault_cleared", 32'(fetch_fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0);
        chk("post_fault_pc", pc, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #2000000;
        fails++;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream neighbour of the main decoder. Owns the PC, fetches instructions over a ready-handshake instruction-memory port, and presents each instruction (opcode field in[31:26]) to decode/datapath for one execute cycle.
- Consumes the decoder's branch/brnv outputs plus ALU flags to select the next PC.
- Holds the architectural overflow flag V used by BRNV, and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] forced to 0.
- IMEM_TIMEOUT, 16, max cycles waiting for imem_ready before flagging a fetch fault.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, held until accepted
- imem_addr  out  32  fetch address (= pc), word aligned
- imem_ready  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word
- instr  out  32  current instruction to decode/datapath
- instr_valid  out  1  high during execute cycle
- pc  out  32  address of current instruction
- pc_plus4  out  32  pc+4, modulo 2^32
- stall  in  1  datapath hold; freezes execute stage
- branch  in  1  decoder beq
- brnv  in  1  decoder brnv
- alu_zero  in  1  ALU zero result
- alu_ovf  in  1  ALU signed overflow
- v_we  in  1  update V flag this execute cycle
- v_flag  out  1  architectural overflow flag
- retired  out  32  instructions retired since reset
- fetch_fault  out  1  sticky timeout indicator

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, imem_req=0, instr=0, instr_valid=0, v_flag=0, retired=0, fetch_fault=0. Outputs take reset values immediately, not at the next edge.
- States: IDLE -> FETCH -> EXEC -> FETCH ..., plus FAULT.
- IDLE: one cycle after reset release, then go to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc. Start the wait counter at 0.
  - imem_ready=1: instr<=imem_rdata, go to EXEC. Minimum fetch latency is 1 cycle.
  - Wait counter reaches IMEM_TIMEOUT with no ready: fetch_fault<=1, go to FAULT.
- EXEC:
  - instr_valid=1, imem_req=0. Decoder and datapath act combinationally on instr.
  - stall=1: hold in EXEC. pc, v_flag and retired are unchanged.
  - stall=0, at the clock edge:
    - Compute taken = (branch & alu_zero) | (brnv & ~v_flag).
    - pc <= taken ? pc_plus4 + (sext(instr[15:0]) << 2) : pc_plus4. All arithmetic is modulo 2^32.
    - If v_we=1: v_flag <= alu_ovf.
    - retired <= retired+1. Wraps from FFFF_FFFF to 0.
    - Go to FETCH.
  - brnv uses the v_flag value held before this cycle's update, even when v_we=1 in the same cycle.
  - branch and brnv both high: taken if either condition holds. No error is raised.
- FAULT: terminal. imem_req=0, instr_valid=0. Only reset exits it.
- imem_ready outside FETCH is ignored. A late response to an abandoned request is discarded.
- Reset asserted mid-FETCH drops imem_req at once and discards any pending response.
- pc[1:0] is always 00.

Test Plan:
- Reset release, RESET_PC=0, imem_ready on 2nd FETCH cycle -> imem_addr=0, instr=rdata, instr_valid 1 cycle, next imem_addr=4, retired=1.
- beq at pc=0x10, imm=0xFFFC, alu_zero=1 -> next pc=0x14+(-4<<2)=0x04. Same with alu_zero=0 -> next pc=0x14.
- v_we=1 with alu_ovf=1, then BRNV imm=3 at pc=0x20 -> not taken, next pc=0x24. After v_we=1 with alu_ovf=0, BRNV at 0x20 -> taken, next pc=0x30. Same-cycle brnv+v_we must use the old V.
- stall held 3 cycles in EXEC -> instr_valid stays 1, pc/retired/v_flag unchanged, then one advance on release.
- imem_ready never asserted -> fetch_fault=1 after 16 FETCH cycles, imem_req=0; rst_n pulse clears the fault and refetches RESET_PC.
- pc=0xFFFF_FFFC non-branch -> next pc=0x0000_0000. rst_n low mid-FETCH -> imem_req falls in the same cycle and the late ready is ignored.
